// File: rtl/mult_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Brief    : Shared types and constants for the round-robin multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int STAT_W      = 16;
    localparam int MUL_LATENCY = 1;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_arbiter_if
// Brief    : Request, multiplier and response signals of the multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int BITS = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_a;
    logic [NREQ*BITS-1:0] req_b;
    logic [BITS-1:0]      mul_a;
    logic [BITS-1:0]      mul_b;
    logic [2*BITS-1:0]    mul_p;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [2*BITS-1:0]    rsp_product;

    // Environment side: requesters, external multiplier and response consumer
    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
    );
endinterface
`default_nettype wire

// File: rtl/mult_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, scans ptr+1, ptr+2, ... mod NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    output logic      [NREQ-1:0] grant,
    output logic      [IDW-1:0]  idx,
    output logic                 any
);
    logic [IDW-1:0] w_cand;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                idx           = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_arbiter
// Brief    : Round-robin arbiter sharing one external registered multiplier.
//            Optional per-requester grant counters under MULT_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int BITS = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mult_rr_arbiter_if.slave      bus
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);
    localparam logic [3:0] c_LAT_LAST = 4'(MUL_LATENCY - 1);

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [BITS-1:0] r_mul_a;
    logic [BITS-1:0] r_mul_b;
    logic [3:0]      r_lat;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_hs;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Grant only in IDLE; a grant is always taken since it follows req_valid
    always_comb begin
        w_next        = r_state;
        w_hs          = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = rst ? '0 : w_grant;
                w_hs          = w_any;
                if (w_any) w_next = ISSUE;
            end
            ISSUE: begin
                if (r_lat == c_LAT_LAST) w_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= IDW'(NREQ - 1);
            r_id    <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_lat   <= '0;
        end else if (w_hs) begin
            r_ptr   <= w_idx;
            r_id    <= w_idx;
            r_mul_a <= bus.req_a[w_idx*BITS +: BITS];
            r_mul_b <= bus.req_b[w_idx*BITS +: BITS];
            r_lat   <= '0;
        end else if (r_state == ISSUE) begin
            r_lat   <= r_lat + 1'b1;
        end
    end

    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_product = bus.rsp_valid ? bus.mul_p : '0;

`ifdef MULT_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [STAT_W-1:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                           r_cnt <= '0;
            else if (w_hs && w_idx == IDW'(i)) r_cnt <= sat_inc(r_cnt);
        end
        assign stat_grants[i*STAT_W +: STAT_W] = r_cnt;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_rr_arbiter
// Brief    : Self-checking bench: cycle model of arbitration plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_rr_arbiter;
    import mult_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int BITS = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_rr_arbiter_if #(.NREQ(NREQ), .BITS(BITS), .IDW(IDW)) bus ();

`ifdef MULT_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] stat_grants;
`endif

    mult_rr_arbiter #(.NREQ(NREQ), .BITS(BITS), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MULT_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    // External registered multiplier sharing rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.mul_p <= '0;
        else     bus.mul_p <= bus.mul_a * bus.mul_b;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a pending transaction answers 1+MUL_LATENCY cycles after its grant
    int              cyc     = 0;
    bit              pending = 1'b0;
    int              hs_cyc  = 0;
    int              m_ptr   = NREQ - 1;
    int              m_id    = 0;
    int              m_a     = 0;
    int              m_b     = 0;
    int              stat2   = 0;
    int              log_id[$];
    int              log_cyc[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        bit              erv;
        int              w;
        int              c;
        cyc++;
        if (rst) begin
            check("rst_req_ready", 32'(bus.req_ready), 0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rst_mul_a", 32'(bus.mul_a), 0);
            check("rst_mul_b", 32'(bus.mul_b), 0);
            check("rst_rsp_id", 32'(bus.rsp_id), 0);
            pending = 1'b0;
            m_ptr   = NREQ - 1;
            m_a     = 0;
            m_b     = 0;
            m_id    = 0;
            stat2   = 0;
        end else begin
            er = '0;
            w  = -1;
            if (!pending) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (w < 0 && bus.req_valid[c]) w = c;
                end
            end
            if (w >= 0) er[w] = 1'b1;
            erv = pending && (cyc - hs_cyc >= 1 + MUL_LATENCY);
            check("model_req_ready", 32'(bus.req_ready), 32'(er));
            check("model_rsp_valid", 32'(bus.rsp_valid), 32'(erv));
            check("model_mul_a", 32'(bus.mul_a), m_a);
            check("model_mul_b", 32'(bus.mul_b), m_b);
            if (erv) begin
                check("model_rsp_id", 32'(bus.rsp_id), m_id);
                check("model_rsp_product", 32'(bus.rsp_product), m_a * m_b);
            end
            if (w >= 0) begin
                pending = 1'b1;
                hs_cyc  = cyc;
                m_id    = w;
                m_ptr   = w;
                m_a     = int'(bus.req_a[w*BITS +: BITS]);
                m_b     = int'(bus.req_b[w*BITS +: BITS]);
                if (w == 2) stat2++;
                log_id.push_back(w);
                log_cyc.push_back(cyc);
            end else if (erv && bus.rsp_ready) begin
                pending = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1 check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        step();

        // Single transaction from req1: 15*15
        bus.req_a[1*BITS +: BITS] = 4'hF;
        bus.req_b[1*BITS +: BITS] = 4'hF;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1 check("single_grant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        #1 check("single_issue_no_rsp", 32'(bus.rsp_valid), 0);
        step();
        #1;
        check("single_rsp_valid", 32'(bus.rsp_valid), 1);
        check("single_rsp_id", 32'(bus.rsp_id), 1);
        check("single_product", 32'(bus.rsp_product), 32'hE1);
        step();

        // Backpressure: req3 6*7 held while req0 keeps asking
        bus.req_a[3*BITS +: BITS] = 4'h6;
        bus.req_b[3*BITS +: BITS] = 4'h7;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1001;
        #1 check("bp_grant", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check("bp_product", 32'(bus.rsp_product), 32'h2A);
            check("bp_rsp_id", 32'(bus.rsp_id), 3);
            check("bp_req_ready", 32'(bus.req_ready), 0);
            step();
        end

        // Asynchronous reset in the middle of RESP
        #2 rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("async_rst_req_ready", 32'(bus.req_ready), 0);
        check("async_rst_mul_a", 32'(bus.mul_a), 0);
        check("async_rst_product", 32'(bus.rsp_product), 0);
        step();

        // Fairness from reset: all requesters valid
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*BITS +: BITS] = 4'(i + 1);
            bus.req_b[i*BITS +: BITS] = 4'(i + 9);
        end
        log_id.delete();
        log_cyc.delete();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1 check("first_grant_after_rst", 32'(bus.req_ready), 32'h1);
        repeat (13) step();
        bus.req_valid = '0;
        check("fair_count", 32'(log_id.size()), 5);
        for (int i = 0; i < 5; i++) begin
            check("fair_order", 32'(log_id[i]), 32'(exp_order[i]));
            if (i > 0) check("fair_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 3);
        end
        repeat (3) step();

        // Reset during ISSUE drops the transaction
        bus.req_a[2*BITS +: BITS] = 4'h3;
        bus.req_b[2*BITS +: BITS] = 4'h5;
        bus.req_valid = 4'b0100;
        #1 check("issue_rst_grant", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        #2 rst = 1'b1;
        step();
        bus.req_a[2*BITS +: BITS] = 4'h2;
        bus.req_b[2*BITS +: BITS] = 4'h2;
        bus.req_valid = 4'b0100;
        rst = 1'b0;
        #1 check("post_rst_idle_grant", 32'(bus.req_ready), 32'h4);
        check("post_rst_no_rsp", 32'(bus.rsp_valid), 0);
        step();
        bus.req_valid = '0;
        #1 check("post_rst_issue_no_rsp", 32'(bus.rsp_valid), 0);
        step();
        #1;
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 1);
        check("post_rst_product", 32'(bus.rsp_product), 32'h04);
        repeat (3) step();

`ifdef MULT_ARB_STATS_EN
        check("stat_req2", 32'(stat_grants[2*STAT_W +: STAT_W]), 32'(stat2));
        check("stat_req0", 32'(stat_grants[0 +: STAT_W]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
